oric_tape_player: RTL and testbench

- Converts a byte stream into the Oric Atmos cassette waveform and drives the tape input of the oricatmos core (K7_TAPEIN).
- Sits between a TAP byte fetcher (upstream, valid/ready) and the core.
- Serialises each byte as an Oric fast-format frame and obeys the motor relay (K7_REMOTE).
- Runs entirely in the 24 MHz system clock domain.

---
 rtl/oric_tape_pkg.sv | 26 ++
 rtl/oric_tape_unit_timer.sv | 51 +++++
 rtl/oric_tape_player.sv | 138 +++++++++++++
 tb/tb_oric_tape_player.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/oric_tape_pkg.sv
// oric_tape_pkg
//   Shared types and helpers for the Oric Atmos cassette player.
//   tape_state_t : player FSM states (IDLE, HIGH, LOW)
//   DATA_BITS    : payload bits per frame
//   oric_parity  : parity bit sent after the data (1 when data has an even number of ones)
//   frame_bits   : total bits per frame for a given number of stop bits
package oric_tape_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } tape_state_t;

  localparam int unsigned DATA_BITS = 8;

  function automatic logic oric_parity(input logic [DATA_BITS-1:0] b);
    return ~^b;
  endfunction

  // start + data + parity + stop
  function automatic int unsigned frame_bits(input int unsigned stop);
    return 1 + DATA_BITS + 1 + stop;
  endfunction

endpackage

// File: rtl/oric_tape_unit_timer.sv
// oric_tape_unit_timer
//   Loadable down-counter measuring a phase of 1 or 2 waveform units.
//   The unit size is re-sampled at the start of every unit.
// Ports:
//   clk_sys        in  system clock
//   reset          in  synchronous active-high reset
//   i_load         in  start a new phase (has priority over counting)
//   i_units        in  phase length in units (1 or 2)
//   i_unit_cycles  in  clock cycles per unit
//   i_en           in  count enable; 0 freezes the timer
//   o_done         out pulse on the last cycle of the phase (only while enabled)
module oric_tape_unit_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             i_load,
  input  logic [1:0]       i_units,
  input  logic [CNT_W-1:0] i_unit_cycles,
  input  logic             i_en,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  // Set while a further whole unit remains after the current one.
  logic             r_left;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt  <= '0;
      r_left <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_unit_cycles - CNT_ONE;
      r_left <= (i_units > 2'd1);
    end else if (i_en) begin
      if (r_cnt == '0) begin
        if (r_left) begin
          r_cnt  <= i_unit_cycles - CNT_ONE;
          r_left <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  assign o_done = i_en && (r_cnt == '0) && !r_left;

endmodule

// File: rtl/oric_tape_player.sv
// oric_tape_player
//   Serialises bytes into the Oric fast-format cassette waveform for K7_TAPEIN.
//   Frame: start 0, data LSB first, parity, STOP_BITS ones. Each bit is 1 unit
//   high followed by 1 unit low ('1') or 2 units low ('0').
//   Optional macro ORIC_TAPE_TURBO_EN adds a turbo input selecting UNIT_CYCLES/8.
// Ports:
//   clk_sys      in  24 MHz system clock
//   reset        in  synchronous active-high reset
//   byte_valid   in  upstream byte available
//   byte_data    in  byte to play (sampled on handshake only)
//   byte_ready   out block accepts a byte this cycle
//   remote       in  motor relay; 0 pauses playback
//   turbo        in  (ORIC_TAPE_TURBO_EN only) shortened unit length
//   tape_out     out cassette waveform
//   busy         out frame in progress, including while paused
//   frame_count  out frames completed since reset, wrapping
module oric_tape_player
  import oric_tape_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 5000,
  parameter int unsigned STOP_BITS   = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        remote,
`ifdef ORIC_TAPE_TURBO_EN
  input  logic        turbo,
`endif
  output logic        tape_out,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned FRAME_BITS = frame_bits(STOP_BITS);
  localparam int unsigned CNT_W      = $clog2(UNIT_CYCLES * 2);
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] UNIT_NORM = CNT_W'(UNIT_CYCLES);

  tape_state_t           r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [15:0]           r_frame_count;

  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic [1:0]       w_units;
  logic             w_done;
  logic [CNT_W-1:0] w_unit_cycles;

`ifdef ORIC_TAPE_TURBO_EN
  localparam logic [CNT_W-1:0] UNIT_FAST = CNT_W'(UNIT_CYCLES / 8);
  assign w_unit_cycles = turbo ? UNIT_FAST : UNIT_NORM;
`else
  assign w_unit_cycles = UNIT_NORM;
`endif

  // Gating with reset keeps the handshake closed while reset is held.
  assign byte_ready = (r_state == IDLE) && remote && !reset;
  assign w_accept   = byte_valid && byte_ready;
  assign w_last     = (r_bit_idx == LAST_IDX);

  // Timer phase loads happen on state transitions so each phase starts counting
  // in its first cycle.
  always_comb begin
    w_load  = 1'b0;
    w_units = 2'd1;
    unique case (r_state)
      IDLE: w_load = w_accept;
      HIGH: begin
        if (w_done) begin
          w_load  = 1'b1;
          w_units = r_shift[0] ? 2'd1 : 2'd2;
        end
      end
      LOW:  w_load = w_done && !w_last;
      default: ;
    endcase
  end

  oric_tape_unit_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .i_load        (w_load),
    .i_units       (w_units),
    .i_unit_cycles (w_unit_cycles),
    .i_en          (remote),
    .o_done        (w_done)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bit_idx     <= '0;
      r_frame_count <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift   <= {{STOP_BITS{1'b1}}, oric_parity(byte_data), byte_data, 1'b0};
            r_bit_idx <= '0;
            r_state   <= HIGH;
          end
        end
        HIGH: begin
          if (w_done) r_state <= LOW;
        end
        LOW: begin
          if (w_done) begin
            if (w_last) begin
              r_state       <= IDLE;
              r_frame_count <= r_frame_count + 16'd1;
            end else begin
              r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
              r_bit_idx <= r_bit_idx + IDX_ONE;
              r_state   <= HIGH;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tape_out    = (r_state == HIGH);
  assign busy        = (r_state != IDLE);
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_oric_tape_player.sv
// Self-checking bench for oric_tape_player with a 10-cycle unit.
module tb_oric_tape_player;

  localparam int unsigned U = 10;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        remote;
  logic        tape_out;
  logic        busy;
  logic [15:0] frame_count;
`ifdef ORIC_TAPE_TURBO_EN
  logic        turbo = 1'b0;
`endif

  always #5 clk_sys = ~clk_sys;

  oric_tape_player #(
    .UNIT_CYCLES (U),
    .STOP_BITS   (4)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .remote      (remote),
`ifdef ORIC_TAPE_TURBO_EN
    .turbo       (turbo),
`endif
    .tape_out    (tape_out),
    .busy        (busy),
    .frame_count (frame_count)
  );

  typedef struct {
    logic [7:0]  data;
    int          cycles;
    logic [13:0] frame;  // bit 0 = first bit on tape
    logic        par;
  } vec_t;

  vec_t        vecs [5];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        tr [0:4095];
  int          tr_n;
  int          total;
  logic [31:0] dec_bits;
  int          dec_n;
  logic        shape_err;
  logic        held_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic start_frame(input logic [7:0] d, input bit hold);
    int guard = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    while (!byte_ready && guard < 20) begin
      @(negedge clk_sys);
      guard++;
    end
    chk("handshake_ready", 32'(byte_ready), 32'd1);
    @(negedge clk_sys);
    if (!hold) begin
      byte_valid = 1'b0;
      byte_data  = 8'h5A;
    end
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_high", 32'(tape_out), 32'd1);
  endtask

  // Records tape_out each busy cycle; optionally pauses remote after sample pause_idx.
  task automatic capture(input int pause_idx, input int pause_len);
    int guard = 0;
    tr_n    = 0;
    total   = 0;
    held_ok = 1'b1;
    while (busy && guard < 4000) begin
      tr[tr_n] = tape_out;
      if (tr_n == pause_idx) begin
        remote = 1'b0;
        repeat (pause_len) begin
          @(negedge clk_sys);
          total++;
          guard++;
          if (tape_out !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b0) held_ok = 1'b0;
        end
        remote = 1'b1;
      end
      tr_n++;
      total++;
      guard++;
      @(negedge clk_sys);
    end
    chk("capture_timeout", 32'(guard < 4000), 32'd1);
  endtask

  task automatic decode();
    int i = 0;
    int h;
    int l;
    dec_n     = 0;
    dec_bits  = '0;
    shape_err = 1'b0;
    while (i < tr_n) begin
      h = 0;
      while (i < tr_n && tr[i] === 1'b1) begin h++; i++; end
      l = 0;
      while (i < tr_n && tr[i] !== 1'b1) begin l++; i++; end
      if (h != U) shape_err = 1'b1;
      if (l == U) dec_bits[dec_n] = 1'b1;
      else if (l == 2 * U) dec_bits[dec_n] = 1'b0;
      else shape_err = 1'b1;
      if (dec_n < 31) dec_n++;
    end
  endtask

  initial begin
    // Durations: '1' = 20 cycles, '0' = 30 cycles; frames are 14 bits.
    vecs[0] = '{8'h16, 350, 14'h3C2C, 1'b0};
    vecs[1] = '{8'h00, 370, 14'h3E00, 1'b1};
    vecs[2] = '{8'h01, 370, 14'h3C02, 1'b0};
    vecs[3] = '{8'hFF, 290, 14'h3FFE, 1'b1};
    vecs[4] = '{8'hA5, 330, 14'h3F4A, 1'b1};

    reset      = 1'b1;
    remote     = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk_sys);
    chk("rst_tape_out", 32'(tape_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(byte_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      start_frame(vecs[v].data, 1'b0);
      capture(-1, 0);
      decode();
      chk($sformatf("v%0d_cycles", v), 32'(total), 32'(vecs[v].cycles));
      chk($sformatf("v%0d_nbits", v), 32'(dec_n), 32'd14);
      chk($sformatf("v%0d_shape", v), 32'(shape_err), 32'd0);
      chk($sformatf("v%0d_frame", v), dec_bits, 32'(vecs[v].frame));
      chk($sformatf("v%0d_parity", v), 32'(dec_bits[9]), 32'(vecs[v].par));
      chk($sformatf("v%0d_ready_after", v), 32'(byte_ready), 32'd1);
      chk($sformatf("v%0d_idle_low", v), 32'(tape_out), 32'd0);
      chk($sformatf("v%0d_frame_count", v), 32'(frame_count), 32'(v + 1));
    end

    // Pause 50 cycles in the LOW phase of bit 3 of 0x16 (samples 90..99).
    start_frame(8'h16, 1'b0);
    capture(92, 50);
    decode();
    chk("pause_cycles", 32'(total), 32'd400);
    chk("pause_held", 32'(held_ok), 32'd1);
    chk("pause_shape", 32'(shape_err), 32'd0);
    chk("pause_frame", dec_bits, 32'h3C2C);
    chk("pause_frame_count", 32'(frame_count), 32'd6);

    // Back-to-back 0xFF with byte_valid held across the frame end.
    start_frame(8'hFF, 1'b1);
    capture(-1, 0);
    decode();
    chk("b2b_first_cycles", 32'(total), 32'd290);
    chk("b2b_first_frame", dec_bits, 32'h3FFE);
    chk("b2b_gap_idle", 32'(busy), 32'd0);
    chk("b2b_gap_low", 32'(tape_out), 32'd0);
    chk("b2b_gap_ready", 32'(byte_ready), 32'd1);
    @(negedge clk_sys);
    chk("b2b_second_busy", 32'(busy), 32'd1);
    chk("b2b_second_high", 32'(tape_out), 32'd1);
    byte_valid = 1'b0;
    capture(-1, 0);
    decode();
    chk("b2b_second_cycles", 32'(total), 32'd290);
    chk("b2b_second_frame", dec_bits, 32'h3FFE);
    chk("b2b_frame_count", 32'(frame_count), 32'd8);

    // Motor off in IDLE blocks the handshake.
    remote     = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h33;
    #1;
    chk("idle_remote_off_ready", 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk_sys);
    chk("idle_remote_off_busy", 32'(busy), 32'd0);
    byte_valid = 1'b0;
    remote     = 1'b1;

    // Reset 100 cycles into a frame aborts it uncounted.
    @(negedge clk_sys);
    start_frame(8'hA5, 1'b0);
    repeat (99) @(negedge clk_sys);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("midrst_tape_out", 32'(tape_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    chk("midrst_ready_in_reset", 32'(byte_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(byte_ready), 32'd1);
    @(negedge clk_sys);
    chk("midrst_stays_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
